// File: rtl/tt_check_pkg.sv
// Shared constants for the truth-table response checker: FSM encodings and size limits.
package tt_check_pkg;

    localparam int MAX_N_IN = 4;
    localparam int CNT_W    = 8;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/truth_table_checker.sv
// Sweeps every input vector onto a combinational block, captures its one-bit response
// after a fixed dwell and compares the assembled truth table against EXP_TT.
module truth_table_checker
    import tt_check_pkg::*;
#(
    parameter int                   N_IN   = 3,
    parameter int                   DWELL  = 4,
    parameter logic [(1<<N_IN)-1:0] EXP_TT = 8'hE8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   dut_y,
    output logic [N_IN-1:0]        dut_in,
    output logic                   busy,
    output logic                   done,
    output logic                   pass,
    output logic [(1<<N_IN)-1:0]   captured,
    output logic [(1<<N_IN)-1:0]   mismatch
);

    localparam int TT_W  = 1 << N_IN;
    // One spare bit keeps the terminal compare from wrapping at 2^N_IN-1.
    localparam int VEC_W = N_IN + 1;

    localparam logic [VEC_W-1:0] VEC_LAST = VEC_W'(TT_W - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);

    logic [1:0]       state_q,    state_d;
    logic [VEC_W-1:0] vec_q,      vec_d;
    logic [CNT_W-1:0] cnt_q,      cnt_d;
    logic [TT_W-1:0]  captured_q, captured_d;
    logic [TT_W-1:0]  mismatch_q, mismatch_d;
    logic             pass_q,     pass_d;
    logic [N_IN-1:0]  idx;

    assign idx = vec_q[N_IN-1:0];

    always_comb begin
        state_d    = state_q;
        vec_d      = vec_q;
        cnt_d      = cnt_q;
        captured_d = captured_q;
        mismatch_d = mismatch_q;
        pass_d     = pass_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d    = ST_RUN;
                    vec_d      = '0;
                    cnt_d      = '0;
                    captured_d = '0;
                    mismatch_d = '0;
                    pass_d     = 1'b0;
                end
            end
            ST_RUN: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d           = '0;
                    captured_d[idx] = dut_y;
                    mismatch_d[idx] = dut_y ^ EXP_TT[idx];
                    if (vec_q == VEC_LAST) begin
                        state_d = ST_DONE;
                        // Verdict must include the bit sampled on this same edge.
                        pass_d  = (captured_d == EXP_TT);
                    end else begin
                        vec_d = vec_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            vec_q      <= '0;
            cnt_q      <= '0;
            captured_q <= '0;
            mismatch_q <= '0;
            pass_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            vec_q      <= vec_d;
            cnt_q      <= cnt_d;
            captured_q <= captured_d;
            mismatch_q <= mismatch_d;
            pass_q     <= pass_d;
        end
    end

    assign dut_in   = (state_q == ST_RUN) ? idx : '0;
    assign busy     = (state_q == ST_RUN);
    assign done     = (state_q == ST_DONE);
    assign pass     = pass_q;
    assign captured = captured_q;
    assign mismatch = mismatch_q;

endmodule

// File: tb/tb_truth_table_checker.sv
// Scoreboard bench: three checker instances (default majority with random faults,
// a tied-high 2-input case, and a late-settling majority at DWELL=2).
module tb_truth_table_checker;

    typedef struct {
        int         s;
        logic [7:0] cap;
        logic [7:0] mm;
        logic       ps;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic maj(input int v);
        return ($countones(v[3:0]) >= 2);
    endfunction

    // Instance 1: default parameters, majority with injectable per-vector faults.
    logic       start1 = 1'b0;
    logic [7:0] fault = 8'h00;
    logic       dut_y1;
    logic [2:0] dut_in1;
    logic       busy1, done1, pass1;
    logic [7:0] captured1, mismatch1;

    assign dut_y1 = maj(int'(dut_in1)) ^ fault[dut_in1];

    truth_table_checker u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .dut_y(dut_y1), .dut_in(dut_in1),
        .busy(busy1), .done(done1), .pass(pass1), .captured(captured1), .mismatch(mismatch1)
    );

    // Instance 2: N_IN=2, DWELL=2, response tied high.
    logic       start2 = 1'b0;
    logic [1:0] dut_in2;
    logic       busy2, done2, pass2;
    logic [3:0] captured2, mismatch2;

    truth_table_checker #(.N_IN(2), .DWELL(2), .EXP_TT(4'b0110)) u_dut2 (
        .clk(clk), .rst(rst), .start(start2), .dut_y(1'b1), .dut_in(dut_in2),
        .busy(busy2), .done(done2), .pass(pass2), .captured(captured2), .mismatch(mismatch2)
    );

    // Instance 3: DWELL=2, majority whose output follows the vector one cycle late.
    logic [2:0] dut_in3;
    logic [2:0] dly_in3 = 3'd0;
    logic       dut_y3;
    logic       busy3, done3, pass3;
    logic [7:0] captured3, mismatch3;

    always @(posedge clk) dly_in3 <= dut_in3;
    assign dut_y3 = maj(int'(dly_in3));

    truth_table_checker #(.N_IN(3), .DWELL(2), .EXP_TT(8'hE8)) u_dut3 (
        .clk(clk), .rst(rst), .start(start2), .dut_y(dut_y3), .dut_in(dut_in3),
        .busy(busy3), .done(done3), .pass(pass3), .captured(captured3), .mismatch(mismatch3)
    );

    exp_t q1[$];
    exp_t q2[$];
    exp_t q3[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor for instance 1: vector schedule during a sweep and results on done.
    int   t1;
    exp_t e1;
    always @(negedge clk) begin
        if (!rst) begin
            if (q1.size() > 0) begin
                t1 = cyc - q1[0].s;
                if (t1 >= 0 && t1 < 32) begin
                    chk("dut_in1", 32'(dut_in1), 32'(t1 / 4));
                    chk("busy1", 32'(busy1), 32'd1);
                end
            end
            if (done1) begin
                chk("done_busy1", 32'(busy1), 32'd0);
                chk("done_in1", 32'(dut_in1), 32'd0);
                if (q1.size() == 0) begin
                    chk("spurious_done1", 32'(done1), 32'd0);
                end else begin
                    e1 = q1.pop_front();
                    chk("latency1", 32'(cyc - e1.s), 32'd32);
                    chk("captured1", 32'(captured1), 32'(e1.cap));
                    chk("mismatch1", 32'(mismatch1), 32'(e1.mm));
                    chk("pass1", 32'(pass1), 32'(e1.ps));
                end
            end
        end
    end

    // Monitor for instances 2 and 3.
    exp_t e2;
    exp_t e3;
    always @(negedge clk) begin
        if (!rst) begin
            if (done2) begin
                if (q2.size() == 0) begin
                    chk("spurious_done2", 32'(done2), 32'd0);
                end else begin
                    e2 = q2.pop_front();
                    chk("latency2", 32'(cyc - e2.s), 32'd8);
                    chk("captured2", 32'(captured2), 32'(e2.cap));
                    chk("mismatch2", 32'(mismatch2), 32'(e2.mm));
                    chk("pass2", 32'(pass2), 32'(e2.ps));
                end
            end
            if (done3) begin
                if (q3.size() == 0) begin
                    chk("spurious_done3", 32'(done3), 32'd0);
                end else begin
                    e3 = q3.pop_front();
                    chk("latency3", 32'(cyc - e3.s), 32'd16);
                    chk("captured3", 32'(captured3), 32'(e3.cap));
                    chk("mismatch3", 32'(mismatch3), 32'(e3.mm));
                    chk("pass3", 32'(pass3), 32'(e3.ps));
                end
            end
        end
    end

    function automatic exp_t model1(input logic [7:0] fmask, input int s);
        exp_t e;
        e.s = s;
        for (int v = 0; v < 8; v++) e.cap[v] = maj(v) ^ fmask[v];
        e.mm = e.cap ^ 8'hE8;
        e.ps = (e.cap == 8'hE8);
        return e;
    endfunction

    task automatic launch1(input logic [7:0] fmask, output int s);
        @(negedge clk);
        fault  = fmask;
        start1 = 1'b1;
        s      = cyc + 1;
        q1.push_back(model1(fmask, s));
        @(negedge clk);
        start1 = 1'b0;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic wait_empty(input int lim);
        int n = 0;
        while ((q1.size() + q2.size() + q3.size()) > 0 && n < lim) begin
            @(negedge clk);
            n++;
        end
        if ((q1.size() + q2.size() + q3.size()) > 0) begin
            chk("timeout_pending", 32'(q1.size() + q2.size() + q3.size()), 32'd0);
            q1.delete(); q2.delete(); q3.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic sweep1(input logic [7:0] fmask);
        int s;
        launch1(fmask, s);
        wait_empty(60);
        repeat ($urandom_range(0, 3)) @(negedge clk);
    endtask

    task automatic chk_zero1(input string tag);
        chk({tag, "_dut_in"},   32'(dut_in1),   32'd0);
        chk({tag, "_busy"},     32'(busy1),     32'd0);
        chk({tag, "_done"},     32'(done1),     32'd0);
        chk({tag, "_pass"},     32'(pass1),     32'd0);
        chk({tag, "_captured"}, 32'(captured1), 32'd0);
        chk({tag, "_mismatch"}, 32'(mismatch1), 32'd0);
    endtask

    initial begin
        int   s;
        exp_t e;

        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk_zero1("reset");
        rst = 1'b0;

        // Nominal majority, then a single fault on vector 3.
        sweep1(8'h00);
        sweep1(8'h08);

        // Random fault patterns, including a fault-free one now and then.
        for (int i = 0; i < 5; i++) begin
            if ($urandom_range(0, 3) == 0) sweep1(8'h00);
            else sweep1(8'($urandom_range(1, 255)));
        end

        // Reset while vector 3 is on the bus, with some captured bits already set.
        launch1(8'h07, s);
        wait_until(s + 13);
        rst = 1'b1;
        q1.delete();
        @(negedge clk);
        chk_zero1("midreset");
        rst = 1'b0;
        repeat (2) @(negedge clk);
        sweep1(8'h00);

        // Start re-pulsed mid-sweep, then held through DONE into the next sweep.
        @(negedge clk);
        fault  = 8'h00;
        start1 = 1'b1;
        s      = cyc + 1;
        q1.push_back(model1(8'h00, s));
        @(negedge clk);
        start1 = 1'b0;
        wait_until(s + 4);
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        wait_until(s + 20);
        start1 = 1'b1;
        q1.push_back(model1(8'h00, s + 34));
        wait_until(s + 34);
        start1 = 1'b0;
        wait_empty(80);

        // Small tied-high table and the late-settling majority, in parallel.
        @(negedge clk);
        start2 = 1'b1;
        s      = cyc + 1;
        e.s = s;
        e.cap = 8'h0F;
        e.mm  = 8'h0F ^ 8'h06;
        e.ps  = 1'b0;
        q2.push_back(e);
        q3.push_back(model1(8'h00, s));
        @(negedge clk);
        start2 = 1'b0;
        wait_empty(40);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
